rx_status_arbiter: RTL
======================

Name: rx_status_arbiter

Overview:
- Multi-lane, registered successor to the per-lane combinational RxStatus encoder.
- Per lane, it collects elastic-buffer, SKP and 8b/10b error events into pending flags.
- It reports them on the PIPE RxStatus code one event per cycle, in priority order, so simultaneous events are never dropped.
- The code is delayed by a programmable number of cycles to align it with the decoded data path. Per-lane saturating error counters feed the debug/status register block.

Parameters:
- LANES, 4, number of independent receive lanes.
- ALIGN_DLY, 2, extra pipeline stages (0..7) after the arbiter register, used to match data-path latency.
- CNT_W, 8, width of each per-lane saturating error counter.

Ports:
- CLK  input  1  receive clock; all state on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Overflow  input  LANES  elastic buffer overflow, one bit per lane, single-cycle pulses.
- Underflow  input  LANES  elastic buffer underflow.
- Skp_Added  input  LANES  SKP symbol inserted by the elastic buffer.
- Skp_Removed  input  LANES  SKP symbol deleted by the elastic buffer.
- Decode_Error  input  LANES  8b/10b invalid code group.
- Disparity_Error  input  LANES  8b/10b running disparity error.
- Cnt_Clr  input  1  synchronous clear of all error counters.
- RxStatus  output  3*LANES  PIPE status code; lane i occupies bits [3i+2:3i].
- Err_Pending  output  LANES  lane has an error-class event (100/101/110/111) pending but not yet reported.
- Err_Cnt  output  CNT_W*LANES  per-lane error counter; lane i occupies bits [CNT_W*i+CNT_W-1:CNT_W*i].

Behaviour:
- Reset (Rst=1, asynchronous) clears every pending flag, every pipeline stage and every counter.
  - RxStatus=0, Err_Pending=0, Err_Cnt=0.
  - Reset asserted mid-operation discards all pending and in-flight codes.
- Lane independence: all lanes are identical and never interact.
- Pending vector per lane, P[5:0], one bit per class. Each class and its code, highest priority first:
  - Decode_Error → 100
  - Overflow → 101
  - Underflow → 110
  - Disparity_Error → 111
  - Skp_Added → 001
  - Skp_Removed → 010
- Arbitration, each cycle:
  - Q = P | inputs.
  - grant = highest-priority set bit of Q.
  - Stage-0 register <= code(grant), or 000 if Q=0.
  - P <= Q & ~grant.
- Event handling rules:
  - An input asserted in the same cycle its class is granted is merged into that report; it is not reported twice.
  - A repeated event of an already-pending class merges; there is no queueing depth beyond one per class.
  - Simultaneous events on one lane are reported on consecutive cycles in priority order.
- Latency: a code reaches RxStatus 1+ALIGN_DLY cycles after the input edge that caused it.
  - ALIGN_DLY=0 means RxStatus is driven directly from stage 0.
  - Delay stages form a plain shift register with no stalls.
- Err_Pending is registered: it equals OR of P[5:2] after the update, i.e. the state visible in the next cycle.
- Err_Cnt counting:
  - Increments by 1 in every cycle where any of Decode_Error, Overflow, Underflow or Disparity_Error is asserted on that lane. Counting is input-side: multiple error inputs in one cycle add 1 in total.
  - Saturates at all-ones, with no wrap-around.
  - SKP events are not counted.
  - Cnt_Clr takes priority over increment: clear plus an error in the same cycle gives 0.
- There are no combinational paths from inputs to outputs.

Test Plan (LANES=4, ALIGN_DLY=2, CNT_W=8):
- Idle after reset, all inputs 0 for 10 cycles → RxStatus=0, Err_Pending=0, Err_Cnt=0 throughout.
- Lane 0 Skp_Added pulse at cycle t → lane 0 RxStatus=001 exactly at cycle t+3 for one cycle; other lanes remain 000.
- Lane 1, one cycle with Decode_Error+Overflow+Skp_Removed asserted together → lane 1 RxStatus 100, 101, 010 on cycles t+3, t+4, t+5.
  - Err_Pending[1]=1 for one cycle, then 0.
  - Err_Cnt lane 1 = 1.
- Lane 2 Disparity_Error held for 300 cycles → Err_Cnt lane 2 saturates at 0xFF and does not wrap.
  - Cnt_Clr together with Disparity_Error → counter reads 0 next cycle, then resumes counting.
- Lane 3 Underflow then Rst pulsed while a code is in the delay pipeline → RxStatus drops to 000 asynchronously.
  - No code emerges after reset release.
- Lane 0 Overflow pending while Overflow re-asserts in its grant cycle → exactly one 101 on RxStatus.

Source files
------------

// File: rtl/rx_status_arbiter.sv
// Multi-lane PIPE RxStatus arbiter: per-lane pending event flags, priority reporting one code
// per cycle, programmable alignment delay and saturating per-lane error counters.
module rx_status_arbiter #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned ALIGN_DLY = 2,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                   CLK,
   input  logic                   Rst,
   input  logic [LANES-1:0]       Overflow,
   input  logic [LANES-1:0]       Underflow,
   input  logic [LANES-1:0]       Skp_Added,
   input  logic [LANES-1:0]       Skp_Removed,
   input  logic [LANES-1:0]       Decode_Error,
   input  logic [LANES-1:0]       Disparity_Error,
   input  logic                   Cnt_Clr,
   output logic [3*LANES-1:0]     RxStatus,
   output logic [LANES-1:0]       Err_Pending,
   output logic [CNT_W*LANES-1:0] Err_Cnt
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   genvar g;
   for (g = 0; g < LANES; g++) begin : g_lane
      // Pending bits, highest priority in bit 5:
      // 5 decode, 4 overflow, 3 underflow, 2 disparity, 1 skp added, 0 skp removed.
      logic [5:0]       r_pend;
      logic [2:0]       r_pipe [0:ALIGN_DLY];
      logic             r_err_pend;
      logic [CNT_W-1:0] r_cnt;

      logic [5:0]       w_ev;
      logic [5:0]       w_q;
      logic [5:0]       w_grant;
      logic [5:0]       w_pend_nxt;
      logic [2:0]       w_code;
      logic             w_err_in;

      assign w_ev = {Decode_Error[g], Overflow[g], Underflow[g],
                     Disparity_Error[g], Skp_Added[g], Skp_Removed[g]};
      assign w_q  = r_pend | w_ev;

      always_comb begin
         w_grant = 6'b000000;
         w_code  = 3'b000;
         if (w_q[5]) begin
            w_grant = 6'b100000;
            w_code  = 3'b100;
         end else if (w_q[4]) begin
            w_grant = 6'b010000;
            w_code  = 3'b101;
         end else if (w_q[3]) begin
            w_grant = 6'b001000;
            w_code  = 3'b110;
         end else if (w_q[2]) begin
            w_grant = 6'b000100;
            w_code  = 3'b111;
         end else if (w_q[1]) begin
            w_grant = 6'b000010;
            w_code  = 3'b001;
         end else if (w_q[0]) begin
            w_grant = 6'b000001;
            w_code  = 3'b010;
         end
      end

      assign w_pend_nxt = w_q & ~w_grant;
      assign w_err_in   = Decode_Error[g] | Overflow[g] | Underflow[g] | Disparity_Error[g];

      always_ff @(posedge CLK or posedge Rst) begin
         if (Rst) begin
            r_pend     <= 6'b000000;
            r_err_pend <= 1'b0;
         end else begin
            r_pend     <= w_pend_nxt;
            r_err_pend <= |w_pend_nxt[5:2];
         end
      end

      // Stage 0 is the arbiter register; the rest is a plain alignment shift register.
      always_ff @(posedge CLK or posedge Rst) begin
         if (Rst) begin
            for (int k = 0; k <= ALIGN_DLY; k++) begin
               r_pipe[k] <= 3'b000;
            end
         end else begin
            r_pipe[0] <= w_code;
            for (int k = 1; k <= ALIGN_DLY; k++) begin
               r_pipe[k] <= r_pipe[k-1];
            end
         end
      end

      always_ff @(posedge CLK or posedge Rst) begin
         if (Rst) begin
            r_cnt <= '0;
         end else if (Cnt_Clr) begin
            r_cnt <= '0;
         end else if (w_err_in && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign RxStatus[3*g +: 3]          = r_pipe[ALIGN_DLY];
      assign Err_Pending[g]              = r_err_pend;
      assign Err_Cnt[CNT_W*g +: CNT_W]   = r_cnt;
   end

endmodule
